alu_seq_ctrl: RTL and testbench

- Multi-cycle sequencer that sits in front of the 32-bit single-cycle ALU and owns its A/B/Op inputs.
- Single-cycle ops (add, sub, and, or, not) are issued once.
- Shift/rotate ops are repeated ShAmt times through the ALU's 1-bit shift functions, giving variable-distance shifts.
- Start/Busy/Done handshake toward the CPU control unit; result is held until the next accepted command.

---
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer driving a 1-cycle ALU; repeats 1-bit shifts ShAmt times.
// Latency: single op Done at cycle 2, shift N>0 at N+1, ShAmt=0/illegal at 1; Start ignored while Busy.
// Optional busy-cycle counter port BusyCycles enabled by defining ALU_SEQ_PERF_EN.
module alu_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [3:0]         Op,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [SHAMT_W-1:0] ShAmt,
  output logic               Busy,
  output logic               Done,
  output logic [DATA_W-1:0]  Result,
  output logic               ResultZero,
  output logic               Err,
  output logic [DATA_W-1:0]  AluA,
  output logic [DATA_W-1:0]  AluB,
  output logic [3:0]         AluOp,
  input  logic [DATA_W-1:0]  AluOut,
  input  logic               AluZero
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]        BusyCycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         op_r;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  b_r;
  logic [SHAMT_W-1:0] cnt;

  function automatic logic is_single(input logic [3:0] op);
    return op <= 4'b0100;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010) ||
           (op == 4'b1100) || (op == 4'b1101);
  endfunction

  // acc holds A during EXEC and the running shift value during SHIFT
  assign AluA  = (state == S_EXEC || state == S_SHIFT) ? acc  : '0;
  assign AluB  = (state == S_EXEC)                     ? b_r  : '0;
  assign AluOp = (state == S_EXEC || state == S_SHIFT) ? op_r : 4'b0000;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      op_r       <= '0;
      acc        <= '0;
      b_r        <= '0;
      cnt        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Result     <= '0;
      ResultZero <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_r <= Op;
            acc  <= A;
            b_r  <= B;
            cnt  <= ShAmt;
            Busy <= 1'b1;
            if (is_single(Op)) begin
              state <= S_EXEC;
            end else if (is_shift(Op) && ShAmt != '0) begin
              state <= S_SHIFT;
            end else if (is_shift(Op)) begin
              state      <= S_DONE;
              Done       <= 1'b1;
              Result     <= A;
              ResultZero <= (A == '0);
              Err        <= 1'b0;
            end else begin
              state      <= S_DONE;
              Done       <= 1'b1;
              Result     <= '0;
              ResultZero <= 1'b1;
              Err        <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          state      <= S_DONE;
          Done       <= 1'b1;
          Result     <= AluOut;
          ResultZero <= AluZero;
          Err        <= 1'b0;
        end
        S_SHIFT: begin
          acc <= AluOut;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state      <= S_DONE;
            Done       <= 1'b1;
            Result     <= AluOut;
            ResultZero <= AluZero;
            Err        <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BusyCycles <= '0;
    end else if (Busy) begin
      BusyCycles <= BusyCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl: behavioural 1-bit ALU plus a whole-command reference model.
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [3:0]  Op;
  logic [31:0] A, B;
  logic [4:0]  ShAmt;
  logic        Busy, Done, ResultZero, Err;
  logic [31:0] Result, AluA, AluB, AluOut;
  logic [3:0]  AluOp;
  logic        AluZero;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] BusyCycles;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_res;
  logic        m_rz, m_err;
  int          exp_bc;

  always #5 Clk = ~Clk;

  alu_seq_ctrl #(.DATA_W(32), .SHAMT_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .ShAmt(ShAmt),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultZero(ResultZero), .Err(Err),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut), .AluZero(AluZero)
`ifdef ALU_SEQ_PERF_EN
    , .BusyCycles(BusyCycles)
`endif
  );

  // single-cycle ALU with 1-bit shift/rotate functions
  always_comb begin
    case (AluOp)
      4'b0000: AluOut = AluA + AluB;
      4'b0001: AluOut = AluA - AluB;
      4'b0010: AluOut = AluA & AluB;
      4'b0011: AluOut = AluA | AluB;
      4'b0100: AluOut = ~AluA;
      4'b1000: AluOut = {AluA[31], AluA[31:1]};
      4'b1001: AluOut = {AluA[30:0], 1'b0};
      4'b1010: AluOut = {1'b0, AluA[31:1]};
      4'b1100: AluOut = {AluA[30:0], AluA[31]};
      4'b1101: AluOut = {AluA[0], AluA[31:1]};
      default: AluOut = 32'd0;
    endcase
  end
  assign AluZero = (AluOut == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // whole-command reference: final value, Done cycle and error flag
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output int lat,
                       output logic err);
    int n;
    n   = int'(sh);
    err = 1'b0;
    lat = (n == 0) ? 1 : n + 1;
    case (op)
      4'b0000: begin res = a + b; lat = 2; end
      4'b0001: begin res = a - b; lat = 2; end
      4'b0010: begin res = a & b; lat = 2; end
      4'b0011: begin res = a | b; lat = 2; end
      4'b0100: begin res = ~a;    lat = 2; end
      4'b1000: res = 32'($signed(a) >>> n);
      4'b1001: res = a << n;
      4'b1010: res = a >> n;
      4'b1100: res = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      4'b1101: res = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      default: begin res = 32'd0; lat = 1; err = 1'b1; end
    endcase
  endtask

  task automatic check_cycle(input int k, input int lat);
    check("busy",   32'(Busy), 32'(k <= lat));
    check("done",   32'(Done), 32'(k == lat));
    check("result", Result, m_res);
    check("rzero",  32'(ResultZero), 32'(m_rz));
    check("err",    32'(Err), 32'(m_err));
    if (k == lat) check("alu_idle", {AluA | AluB, 28'd0, AluOp} != 64'd0 ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit b2b);
    logic [31:0] r;
    int          lat;
    logic        e;
    int          last;
    model(op, a, b, sh, r, lat, e);
    @(negedge Clk);
    check("idle_busy", 32'(Busy), 32'd0);
    Start = 1'b1; Op = op; A = a; B = b; ShAmt = sh;
    last = b2b ? lat : lat + 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge Clk);
      // scramble inputs and fire ignored Starts while the command is in flight
      Start = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      Op = 4'($urandom); A = $urandom; B = $urandom; ShAmt = 5'($urandom);
      if (k == lat) begin
        m_res = r; m_rz = (r == 32'd0); m_err = e;
      end
      if (k <= lat) exp_bc++;
      check_cycle(k, lat);
    end
  endtask

  task automatic run_reset_abort();
    logic [31:0] a;
    a = $urandom | 32'h1;
    @(negedge Clk);
    Start = 1'b1; Op = 4'b1010; A = a; B = $urandom; ShAmt = 5'd20;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      Start = 1'($urandom_range(0, 1));
      A = $urandom;
      exp_bc++;
      check("abort_busy", 32'(Busy), 32'd1);
      check("abort_done", 32'(Done), 32'd0);
      if (k == 10) Reset = 1'b1;
    end
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    m_res = 32'd0; m_rz = 1'b0; m_err = 1'b0; exp_bc = 0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_rzero", 32'(ResultZero), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_alua", AluA, 32'd0);
    check("rst_aluop", 32'(AluOp), 32'd0);
`ifdef ALU_SEQ_PERF_EN
    check("rst_busycycles", BusyCycles, 32'd0);
`endif
    repeat (3) begin
      @(negedge Clk);
      check("post_rst_done", 32'(Done), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] ops[12];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd7, 4'd15};
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0; ShAmt = '0;
    m_res = 32'd0; m_rz = 1'b0; m_err = 1'b0; exp_bc = 0;
    repeat (2) @(negedge Clk);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_result", Result, 32'd0);
    check("reset_rzero", 32'(ResultZero), 32'd0);
    check("reset_err", 32'(Err), 32'd0);
    check("reset_alub", AluB, 32'd0);
    Reset = 1'b0;

    run_cmd(4'b0000, 32'd5, 32'd7, 5'd0, 1'b0);
    check("add_5_7", m_res, Result);
    run_cmd(4'b0001, 32'd3, 32'd3, 5'd0, 1'b1);
    run_cmd(4'b0000, 32'd1, 32'd2, 5'd0, 1'b0);
    run_cmd(4'b1001, 32'd1, 32'd0, 5'd31, 1'b0);
    run_cmd(4'b1000, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
    check("sra_value", Result, 32'hF800_0000);
    run_cmd(4'b1101, 32'd1, 32'd0, 5'd1, 1'b0);
    check("ror_value", Result, 32'h8000_0000);
    run_cmd(4'b1100, 32'h1234, 32'd0, 5'd0, 1'b0);
    run_cmd(4'b0111, 32'hdead, 32'hbeef, 5'd3, 1'b0);
    run_cmd(4'b0010, 32'hf0f0, 32'h0ff0, 5'd0, 1'b0);
    run_reset_abort();

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      run_cmd(ops[$urandom_range(0, 11)], ra, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef ALU_SEQ_PERF_EN
    @(negedge Clk);
    check("busycycles", BusyCycles, 32'(exp_bc));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
